gate_test_sequencer: RTL
========================

GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 SHALL have parameter HOLD_W, default 8, the width of the HOLD and SETTLE fields.
REQ-002 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port START  input  1  request one test run; sampled only in IDLE.
REQ-005 SHALL have port FUNC  input  3  expected gate function, latched at START.
REQ-006 SHALL have port HOLD  input  HOLD_W  cycles per vector, latched at START; 0 is treated as 1.
REQ-007 SHALL have port SETTLE  input  HOLD_W  cycle offset within a vector at which Y is sampled, latched at START.
REQ-008 SHALL have port A  output  1  DUT input A.
REQ-009 SHALL have port B  output  1  DUT input B.
REQ-010 SHALL have port Y  input  1  DUT output, asynchronous to CLK.
REQ-011 SHALL have port BUSY  output  1  high while a run is in progress.
REQ-012 SHALL have port DONE  output  1  one-cycle pulse at the end of a run.
REQ-013 SHALL have port PASS  output  1  result of the last run; 1 = all four vectors matched.
REQ-014 SHALL have port ERR_CNT  output  3  mismatch count of the last run, 0..4.
REQ-015 SHALL have port FAIL_VEC  output  4  bit i set when vector i ({A,B}=i) mismatched.

Function
REQ-016 SHALL encode FUNC as: 0 NOR, 1 NAND, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6 NOT_A, 7 BUF_A.
REQ-017 SHALL hold the expected value per FUNC as a 4-bit truth table indexed by {A,B}; NOR = 4'b0001 (bit0 = vector 00).
REQ-018 SHALL pass Y through a two-flop synchronizer before any comparison.
REQ-019 SHALL implement the states IDLE, DRIVE, REPORT; transitions: IDLE->DRIVE on START; DRIVE->DRIVE on vector advance; DRIVE->REPORT after vector 3 completes; REPORT->IDLE unconditionally after one cycle.
REQ-020 SHALL apply vectors in the order {A,B} = 00, 01, 10, 11 (B toggles fastest).
REQ-021 SHALL, on the edge that accepts START, set BUSY=1 and A=B=0, and clear ERR_CNT, FAIL_VEC and PASS.
REQ-022 SHALL hold each vector for exactly H = max(HOLD,1) cycles; the hold counter runs 0..H-1.
REQ-023 SHALL sample synchronized Y once per vector, when the hold counter equals S = min(SETTLE, H-1).
REQ-024 SHALL, on a mismatch, increment ERR_CNT (saturating at 4) and set the FAIL_VEC bit for that vector.
REQ-025 SHALL keep BUSY high for exactly 4*H+1 cycles, the last of which is REPORT.
REQ-026 SHALL pulse DONE for the REPORT cycle only, set PASS = (ERR_CNT==0) on the same edge, and drop BUSY on the following edge.
REQ-027 SHALL ignore START while BUSY; a START asserted during the REPORT cycle is also ignored.
REQ-028 SHALL ignore FUNC, HOLD and SETTLE changes during a run.
REQ-029 SHALL drive A=B=0 in IDLE, and hold PASS, ERR_CNT and FAIL_VEC stable until the next accepted START.

Reset
REQ-030 SHALL, while RST_N=0, asynchronously force state IDLE and A, B, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC, the counters and the synchronizer flops to 0.
REQ-031 SHALL abort a run on reset without producing DONE, and SHALL accept START on the first rising CLK edge after RST_N deasserts.

Structure
REQ-032 SHALL place the FUNC code constants, the truth-table constant array and the state enum in a shared package gate_test_pkg.
REQ-033 SHALL implement the synchronizer as sub-module sync2 (CLK, RST_N, D, Q).

Verification
REQ-034 SHALL cover the NOR pass case: FUNC=0, HOLD=4, SETTLE=3, model Y = ~(A|B) -> BUSY high for 17 cycles, DONE one pulse, PASS=1, ERR_CNT=0, FAIL_VEC=0000.
REQ-035 SHALL cover a stuck-at fault: FUNC=0, HOLD=4, SETTLE=3, Y tied 0 -> PASS=0, ERR_CNT=1, FAIL_VEC=0001.
REQ-036 SHALL cover clamping: HOLD=0, SETTLE=5, FUNC=3, model OR -> each vector lasts 1 cycle, BUSY lasts 5 cycles, synchronizer latency yields mismatches, ERR_CNT>0; the same run repeated with HOLD=4, SETTLE=7 -> sample at count 3, PASS=1.
REQ-037 SHALL cover reset mid-run: RST_N pulsed low during vector 2 -> all outputs 0 immediately, no DONE; a new START completes normally.
REQ-038 SHALL cover START and config changes while BUSY: a second START and a FUNC change mid-run -> no restart, result computed with the originally latched FUNC.
REQ-039 SHALL cover all-fail saturation: FUNC=5 (XNOR), model XOR -> ERR_CNT=4, FAIL_VEC=1111, PASS=0.

Source files
------------

// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate test sequencer.
// Contents:
//   FUNC_* codes   - 3-bit gate function selector values
//   TRUTH_TABLE    - expected output per function, bit index = {a,b}
//   state_t        - sequencer FSM state encoding
package gate_test_pkg;

    localparam logic [2:0] FUNC_NOR   = 3'd0;
    localparam logic [2:0] FUNC_NAND  = 3'd1;
    localparam logic [2:0] FUNC_AND   = 3'd2;
    localparam logic [2:0] FUNC_OR    = 3'd3;
    localparam logic [2:0] FUNC_XOR   = 3'd4;
    localparam logic [2:0] FUNC_XNOR  = 3'd5;
    localparam logic [2:0] FUNC_NOT_A = 3'd6;
    localparam logic [2:0] FUNC_BUF_A = 3'd7;

    // Indexed by function code; bit 0 is vector {a,b}=00.
    localparam logic [3:0] TRUTH_TABLE [8] = '{
        4'b0001,    // NOR
        4'b0111,    // NAND
        4'b1000,    // AND
        4'b1110,    // OR
        4'b0110,    // XOR
        4'b1001,    // XNOR
        4'b0011,    // NOT_A
        4'b1100     // BUF_A
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both flops
//   d     - asynchronous input
//   q     - synchronized output (two clk cycles of latency)
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gate_test_sequencer.sv
// Drives the four input vectors of a two-input gate under test, samples its
// output once per vector and reports mismatches against the expected function.
// Ports:
//   clk, rst_n     - clock and asynchronous active-low reset
//   start          - request a run (honoured only in IDLE)
//   func           - expected gate function code, latched at start
//   hold           - cycles per vector (0 behaves as 1), latched at start
//   settle         - sample offset within a vector, latched at start
//   a, b           - stimulus to the gate under test
//   y              - gate output, asynchronous to clk
//   busy, done     - run in progress / one-cycle end-of-run pulse
//   pass, err_cnt, fail_vec - result of the last completed run
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | a=b=0, results held, waiting for start
// ST_DRIVE  | applying vector vec for H cycles, sampling y at count S
// ST_REPORT | single cycle: done high, busy drops on the next edge
module gate_test_sequencer
    import gate_test_pkg::*;
#(
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        func,
    input  logic [HOLD_W-1:0] hold,
    input  logic [HOLD_W-1:0] settle,
    output logic              a,
    output logic              b,
    input  logic              y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [2:0]        err_cnt,
    output logic [3:0]        fail_vec
);

    state_t            state;
    logic [2:0]        func_q;
    logic [HOLD_W-1:0] hold_last;   // H-1, terminal count of the hold counter
    logic [HOLD_W-1:0] sample_pt;   // S = min(settle, H-1)
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        vec;
    logic              y_sync;

    logic [HOLD_W-1:0] hold_eff_m1;
    logic [HOLD_W-1:0] settle_eff;
    logic              sample_now;
    logic              mismatch;
    logic              vec_end;
    logic [2:0]        err_next;
    logic [3:0]        fail_next;

    sync2 u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (y),
        .q     (y_sync)
    );

    always_comb begin
        hold_eff_m1 = (hold == '0) ? '0 : hold - HOLD_W'(1);
        settle_eff  = (settle > hold_eff_m1) ? hold_eff_m1 : settle;

        sample_now = (state == ST_DRIVE) && (hold_cnt == sample_pt);
        mismatch   = sample_now && (y_sync != TRUTH_TABLE[func_q][vec]);
        vec_end    = (hold_cnt == hold_last);

        err_next  = err_cnt;
        fail_next = fail_vec;
        if (mismatch) begin
            if (err_cnt != 3'd4) begin
                err_next = err_cnt + 3'd1;
            end
            fail_next = fail_vec | (4'b0001 << vec);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            func_q    <= '0;
            hold_last <= '0;
            sample_pt <= '0;
            hold_cnt  <= '0;
            vec       <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            fail_vec  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_DRIVE;
                        func_q    <= func;
                        hold_last <= hold_eff_m1;
                        sample_pt <= settle_eff;
                        hold_cnt  <= '0;
                        vec       <= 2'd0;
                        a         <= 1'b0;
                        b         <= 1'b0;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        err_cnt   <= '0;
                        fail_vec  <= '0;
                    end
                end
                ST_DRIVE: begin
                    err_cnt  <= err_next;
                    fail_vec <= fail_next;
                    if (vec_end) begin
                        hold_cnt <= '0;
                        if (vec == 2'd3) begin
                            // Last sample may land on this same edge, so the
                            // verdict uses the updated count.
                            state <= ST_REPORT;
                            done  <= 1'b1;
                            pass  <= (err_next == 3'd0);
                            a     <= 1'b0;
                            b     <= 1'b0;
                        end else begin
                            vec    <= vec + 2'd1;
                            {a, b} <= vec + 2'd1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                ST_REPORT: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
